// File: rtl/polar_encoder.sv
// polar_encoder: sequential polar-code encoder, scatter info bits into free positions then log2(N) XOR butterfly stages
// clk_i/rst_i       clock, synchronous active-high reset
// in_valid_i/in_ready_o, info_i, frozen_i   job input handshake; info packed LSB-first, frozen bit = 1 forces 0
// out_valid_o/out_ready_i, codeword_o, k_o  codeword output handshake; k_o = info bits consumed
module polar_encoder #(
  parameter int N = 64,
  localparam int LOG2N = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [N-1:0]     info_i,
  input  logic [N-1:0]     frozen_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [N-1:0]     codeword_o,
  output logic [LOG2N:0]   k_o
);
  typedef enum logic [1:0] {IDLE, MAP, ENC, OUT} state_t;
  state_t st;
  logic [N-1:0] info, frozen, u, sh, nx;
  logic [LOG2N-1:0] idx, s;
  logic [LOG2N:0] ptr;
  // partner of position b in stage s is b + 2^s; only positions with bit s clear update
  assign sh = u >> (32'd1 << s);
  for (genvar b = 0; b < N; b++) begin : g_bf
    assign nx[b] = ((b >> s) & 1) != 0 ? u[b] : u[b] ^ sh[b];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st <= IDLE;
      info <= '0;
      frozen <= '0;
      u <= '0;
      idx <= '0;
      ptr <= '0;
      s <= '0;
    end else begin
      case (st)
        IDLE: if (in_valid_i) begin
          info <= info_i;
          frozen <= frozen_i;
          u <= '0;
          idx <= '0;
          ptr <= '0;
          st <= MAP;
        end
        MAP: begin
          if (!frozen[idx]) begin
            u[idx] <= info[ptr[LOG2N-1:0]];
            ptr <= ptr + 1'b1;
          end
          idx <= idx + 1'b1;
          if (idx == LOG2N'(N - 1)) begin
            st <= ENC;
            s <= '0;
          end
        end
        ENC: begin
          u <= nx;
          s <= s + 1'b1;
          if (s == LOG2N'(LOG2N - 1)) st <= OUT;
        end
        OUT: if (out_ready_i) st <= IDLE;
      endcase
    end
  end
  assign in_ready_o = st == IDLE;
  assign out_valid_o = st == OUT;
  assign codeword_o = u;
  assign k_o = ptr;
endmodule

// File: tb/tb_polar_encoder.sv
// tb_polar_encoder: randomized check of polar_encoder (N=8 and N=64) against a scatter + u*F^{(x)n} model
module tb_polar_encoder;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic iv8, ir8, ov8, or8;
  logic [7:0] inf8, frz8, cw8;
  logic [3:0] k8;
  logic iv64, ir64, ov64, or64;
  logic [63:0] inf64, frz64, cw64;
  logic [6:0] k64;
  int n_vec = 0, n_err = 0;

  polar_encoder #(.N(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv8), .in_ready_o(ir8), .info_i(inf8), .frozen_i(frz8),
    .out_valid_o(ov8), .out_ready_i(or8), .codeword_o(cw8), .k_o(k8));
  polar_encoder #(.N(64)) dut64 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv64), .in_ready_o(ir64), .info_i(inf64), .frozen_i(frz64),
    .out_valid_o(ov64), .out_ready_i(or64), .codeword_o(cw64), .k_o(k64));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_enc(input int n, input logic [63:0] info, input logic [63:0] frz, output int k);
    logic [63:0] u, x;
    u = '0;
    x = '0;
    k = 0;
    for (int i = 0; i < n; i++)
      if (!frz[i]) begin
        u[i] = info[k];
        k++;
      end
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        if ((j & i) == i) x[i] = x[i] ^ u[j];
    return x;
  endfunction

  task automatic drive(input int n, input logic iv, input logic [63:0] info, input logic [63:0] frz, input logic ordy);
    if (n == 8) begin
      iv8 = iv; inf8 = info[7:0]; frz8 = frz[7:0]; or8 = ordy;
    end else begin
      iv64 = iv; inf64 = info; frz64 = frz; or64 = ordy;
    end
  endtask

  task automatic sample(input int n, output logic ov, output logic ir, output logic [63:0] cw, output int k);
    if (n == 8) begin
      ov = ov8; ir = ir8; cw = {56'b0, cw8}; k = int'(k8);
    end else begin
      ov = ov64; ir = ir64; cw = cw64; k = int'(k64);
    end
  endtask

  task automatic scramble(input int n);
    drive(n, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
  endtask

  task automatic run_job(input int n, input logic [63:0] info, input logic [63:0] frz, input int hold,
                         input string tag, output logic [63:0] cw_out, output int k_out);
    int lg, k_exp, k, k0, c;
    logic [63:0] exp, cw, cw0;
    logic ov, ir, stable;
    lg = n == 8 ? 3 : 6;
    exp = ref_enc(n, info, frz, k_exp);
    @(negedge clk);
    sample(n, ov, ir, cw, k);
    chk({tag, ".ready"}, ir, 1);
    drive(n, 1, info, frz, 0);
    @(posedge clk); #1;
    c = 0;
    sample(n, ov, ir, cw, k);
    while (!ov && c < 200) begin
      scramble(n);
      @(posedge clk); #1;
      c++;
      sample(n, ov, ir, cw, k);
    end
    drive(n, 0, {$urandom, $urandom}, {$urandom, $urandom}, 0);
    chk({tag, ".cycle"}, c + 1, n + lg + 1);
    chk({tag, ".cw"}, cw, exp);
    chk({tag, ".k"}, k, k_exp);
    cw_out = cw;
    k_out = k;
    cw0 = cw;
    k0 = k;
    stable = 1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      sample(n, ov, ir, cw, k);
      if (cw !== cw0 || k != k0 || !ov || ir) stable = 0;
    end
    if (hold > 0) chk({tag, ".hold"}, stable, 1);
    drive(n, 0, 0, 0, 1);
    @(posedge clk); #1;
    drive(n, 0, 0, 0, 0);
    sample(n, ov, ir, cw, k);
    chk({tag, ".idle"}, {ov, ir}, 2'b01);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] cw, info, frz;
    int k, n;
    logic ov, ir;
    drive(8, 0, 0, 0, 0);
    drive(64, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ir8", ir8, 1);
    chk("rst.ov8", ov8, 0);
    chk("rst.cw8", cw8, 0);
    chk("rst.k8", k8, 0);
    chk("rst.ir64", ir64, 1);
    chk("rst.ov64", ov64, 0);
    chk("rst.cw64", cw64, 0);
    chk("rst.k64", k64, 0);
    rst = 0;
    run_job(8, 64'h0B, 64'h17, 0, "tp8", cw, k);
    chk("tp8.c3", cw, 64'hC3);
    chk("tp8.k4", k, 4);
    run_job(64, 64'h1, 64'h0, 0, "free1", cw, k);
    chk("free1.val", cw, 64'h1);
    chk("free1.k64", k, 64);
    run_job(64, 64'h8000_0000_0000_0000, 64'h0, 0, "freemsb", cw, k);
    chk("freemsb.val", cw, '1);
    run_job(64, {$urandom, $urandom}, '1, 0, "allfrz", cw, k);
    chk("allfrz.val", cw, 0);
    chk("allfrz.k0", k, 0);
    run_job(8, {$urandom, $urandom}, {$urandom, $urandom}, 20, "bp", cw, k);
    run_job(8, {$urandom, $urandom}, {$urandom, $urandom}, 0, "bp2", cw, k);
    @(negedge clk);
    drive(64, 1, '1, 64'h0, 0);
    @(posedge clk); #1;
    drive(64, 0, 0, 0, 0);
    repeat (64 + 2) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    sample(64, ov, ir, cw, k);
    chk("midrst.ir", ir, 1);
    chk("midrst.ov", ov, 0);
    chk("midrst.cw", cw, 0);
    run_job(64, {$urandom, $urandom}, {$urandom, $urandom}, 0, "postrst", cw, k);
    for (int i = 0; i < 1000; i++) begin
      n = i % 2 ? 64 : 8;
      info = {$urandom, $urandom};
      case ($urandom % 8)
        0: frz = '0;
        1: frz = '1;
        default: frz = {$urandom, $urandom};
      endcase
      run_job(n, info, frz, int'($urandom % 4), "rnd", cw, k);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
